bcfg_register_bank: RTL and testbench

- Bank of the three 16-bit base-configuration registers BCFG1, BCFG2 and BCFG3, each with its own write strobe.
- Decodes each register into the fields read by the convolution layer: engine count, matrix size, split shift amount and final shift.
- Written by the host/command path; read continuously by the compute datapath.

---
 rtl/bcfg_pkg.sv | 45 ++++
 rtl/bcfg_register_bank_if.sv | 34 +++
 rtl/bcfg_register_bank_cfg_register.sv | 28 ++
 rtl/bcfg_register_bank.sv | 67 ++++++
 tb/tb_bcfg_register_bank.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/bcfg_pkg.sv
// Shared field layout, reserved masks and register typedefs for the base-configuration bank.
// The engine-count clamp helper backs the optional BCFG_ENGINE_CLAMP_EN build.
package bcfg_pkg;

  localparam int REG_W         = 16;
  localparam int ENGINE_COUNT_W = 10;
  localparam int SHIFT_LOW_W   = 4;
  localparam int MATRIX_SIZE_W = 14;
  localparam int SHIFT_HIGH_W  = 2;
  localparam int SHIFT_FINAL_W = 6;
  localparam int SHIFT_AMOUNT_W = SHIFT_HIGH_W + SHIFT_LOW_W;

  localparam logic [REG_W-1:0] BCFG1_MASK = 16'h3FFF;
  localparam logic [REG_W-1:0] BCFG2_MASK = 16'hFFFF;
  localparam logic [REG_W-1:0] BCFG3_MASK = 16'h003F;

  typedef struct packed {
    logic [1:0]                rsvd;
    logic [SHIFT_LOW_W-1:0]    shift_low;
    logic [ENGINE_COUNT_W-1:0] engine_count;
  } bcfg1_t;

  typedef struct packed {
    logic [SHIFT_HIGH_W-1:0]  shift_high;
    logic [MATRIX_SIZE_W-1:0] matrix_size;
  } bcfg2_t;

  typedef struct packed {
    logic [9:0]               rsvd;
    logic [SHIFT_FINAL_W-1:0] shift_final;
  } bcfg3_t;

  // Saturates engine_count into 1..max_count when enabled, otherwise passes it through.
  function automatic logic [ENGINE_COUNT_W-1:0] clamp_engine_count(
    input logic [ENGINE_COUNT_W-1:0] value,
    input logic [ENGINE_COUNT_W-1:0] max_count,
    input logic                      enable
  );
    if (!enable)              return value;
    if (value == '0)          return ENGINE_COUNT_W'(1);
    if (value > max_count)    return max_count;
    return value;
  endfunction

endpackage

// File: rtl/bcfg_register_bank_if.sv
// Host-side write strobes/data and decoded configuration fields of the BCFG register bank.
interface bcfg_register_bank_if;
  import bcfg_pkg::*;

  logic                      bcfg1_we_i;
  logic [REG_W-1:0]          bcfg1_data_i;
  logic                      bcfg2_we_i;
  logic [REG_W-1:0]          bcfg2_data_i;
  logic                      bcfg3_we_i;
  logic [REG_W-1:0]          bcfg3_data_i;

  logic [REG_W-1:0]          bcfg1_o;
  logic [REG_W-1:0]          bcfg2_o;
  logic [REG_W-1:0]          bcfg3_o;
  logic [ENGINE_COUNT_W-1:0] engine_count_o;
  logic [SHIFT_LOW_W-1:0]    shift_low_o;
  logic [MATRIX_SIZE_W-1:0]  matrix_size_o;
  logic [SHIFT_HIGH_W-1:0]   shift_high_o;
  logic [SHIFT_FINAL_W-1:0]  shift_final_o;
  logic [SHIFT_AMOUNT_W-1:0] shift_amount_o;

  modport master (
    output bcfg1_we_i, bcfg1_data_i, bcfg2_we_i, bcfg2_data_i, bcfg3_we_i, bcfg3_data_i,
    input  bcfg1_o, bcfg2_o, bcfg3_o, engine_count_o, shift_low_o, matrix_size_o,
           shift_high_o, shift_final_o, shift_amount_o
  );

  modport slave (
    input  bcfg1_we_i, bcfg1_data_i, bcfg2_we_i, bcfg2_data_i, bcfg3_we_i, bcfg3_data_i,
    output bcfg1_o, bcfg2_o, bcfg3_o, engine_count_o, shift_low_o, matrix_size_o,
           shift_high_o, shift_final_o, shift_amount_o
  );

endinterface

// File: rtl/bcfg_register_bank_cfg_register.sv
// Generic 16-bit async-reset register with write enable; reserved bits (Mask=0) are held at 0.
module cfg_register
  import bcfg_pkg::*;
#(
  parameter logic [REG_W-1:0] ResetValue = '0,
  parameter logic [REG_W-1:0] Mask       = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [REG_W-1:0] d_i,
  output logic [REG_W-1:0] q_o
);

  logic [REG_W-1:0] q_q;
  logic [REG_W-1:0] q_d;

  assign q_d = we_i ? (d_i & Mask) : q_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= ResetValue & Mask;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/bcfg_register_bank.sv
// BCFG1..BCFG3 base-configuration registers with combinational field decode.
// Define BCFG_ENGINE_CLAMP_EN to saturate written engine_count into 1..MaxEngineCount.
module bcfg_register_bank
  import bcfg_pkg::*;
#(
  parameter logic [REG_W-1:0]          Bcfg1ResetValue = 16'h0001,
  parameter logic [REG_W-1:0]          Bcfg2ResetValue = 16'h0000,
  parameter logic [REG_W-1:0]          Bcfg3ResetValue = 16'h0000,
  parameter logic [ENGINE_COUNT_W-1:0] MaxEngineCount  = 10'd1023
) (
  input logic                  clk_i,
  input logic                  rst_i,
  bcfg_register_bank_if.slave  bus
);

`ifdef BCFG_ENGINE_CLAMP_EN
  localparam logic ClampEn = 1'b1;
`else
  localparam logic ClampEn = 1'b0;
`endif

  bcfg1_t bcfg1_wdata;
  bcfg1_t bcfg1_q;
  bcfg2_t bcfg2_q;
  bcfg3_t bcfg3_q;

  // Clamp applies to written data only; the reset value is loaded as given.
  always_comb begin
    bcfg1_wdata              = bcfg1_t'(bus.bcfg1_data_i);
    bcfg1_wdata.engine_count = clamp_engine_count(bcfg1_wdata.engine_count, MaxEngineCount, ClampEn);
  end

  cfg_register #(.ResetValue(Bcfg1ResetValue), .Mask(BCFG1_MASK)) u_bcfg1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we_i  (bus.bcfg1_we_i),
    .d_i   (bcfg1_wdata),
    .q_o   (bcfg1_q)
  );

  cfg_register #(.ResetValue(Bcfg2ResetValue), .Mask(BCFG2_MASK)) u_bcfg2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we_i  (bus.bcfg2_we_i),
    .d_i   (bus.bcfg2_data_i),
    .q_o   (bcfg2_q)
  );

  cfg_register #(.ResetValue(Bcfg3ResetValue), .Mask(BCFG3_MASK)) u_bcfg3 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we_i  (bus.bcfg3_we_i),
    .d_i   (bus.bcfg3_data_i),
    .q_o   (bcfg3_q)
  );

  assign bus.bcfg1_o        = bcfg1_q;
  assign bus.bcfg2_o        = bcfg2_q;
  assign bus.bcfg3_o        = bcfg3_q;
  assign bus.engine_count_o = bcfg1_q.engine_count;
  assign bus.shift_low_o    = bcfg1_q.shift_low;
  assign bus.matrix_size_o  = bcfg2_q.matrix_size;
  assign bus.shift_high_o   = bcfg2_q.shift_high;
  assign bus.shift_final_o  = bcfg3_q.shift_final;
  assign bus.shift_amount_o = {bcfg2_q.shift_high, bcfg1_q.shift_low};

endmodule

// File: tb/tb_bcfg_register_bank.sv
// Scoreboard bench for bcfg_register_bank: stimulus queues expected register images,
// a monitor samples the DUT on each observation point and compares every output.
module tb_bcfg_register_bank;

  logic clk;
  logic rst;

  bcfg_register_bank_if bus ();

  bcfg_register_bank #(.MaxEngineCount(10'd2)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [15:0] b1;
    logic [15:0] b2;
    logic [15:0] b3;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Held low at start so the reset check sees no clock edge.
  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_now(input string name, input logic [15:0] b1, input logic [15:0] b2,
                            input logic [15:0] b3);
    exp_t e;
    e.name = name;
    e.b1 = b1;
    e.b2 = b2;
    e.b3 = b3;
    q.push_back(e);
    ->sample_ev;
    #1;
  endtask

  task automatic write_regs(input logic w1, input logic w2, input logic w3,
                            input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
    @(negedge clk);
    bus.bcfg1_we_i = w1; bus.bcfg1_data_i = d1;
    bus.bcfg2_we_i = w2; bus.bcfg2_data_i = d2;
    bus.bcfg3_we_i = w3; bus.bcfg3_data_i = d3;
    @(negedge clk);
    bus.bcfg1_we_i = 1'b0;
    bus.bcfg2_we_i = 1'b0;
    bus.bcfg3_we_i = 1'b0;
  endtask

  // Monitor: compares readbacks and decoded fields against the queued register image.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: sample with empty queue");
      end else begin
        e = q.pop_front();
        check({e.name, ".bcfg1"},        bus.bcfg1_o, e.b1);
        check({e.name, ".bcfg2"},        bus.bcfg2_o, e.b2);
        check({e.name, ".bcfg3"},        bus.bcfg3_o, e.b3);
        check({e.name, ".engine_count"}, {6'd0, bus.engine_count_o}, {6'd0, e.b1[9:0]});
        check({e.name, ".shift_low"},    {12'd0, bus.shift_low_o},   {12'd0, e.b1[13:10]});
        check({e.name, ".matrix_size"},  {2'd0, bus.matrix_size_o},  {2'd0, e.b2[13:0]});
        check({e.name, ".shift_high"},   {14'd0, bus.shift_high_o},  {14'd0, e.b2[15:14]});
        check({e.name, ".shift_final"},  {10'd0, bus.shift_final_o}, {10'd0, e.b3[5:0]});
        check({e.name, ".shift_amount"}, {10'd0, bus.shift_amount_o},
              {10'd0, e.b2[15:14], e.b1[13:10]});
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.bcfg1_we_i = 1'b0; bus.bcfg1_data_i = '0;
    bus.bcfg2_we_i = 1'b0; bus.bcfg2_data_i = '0;
    bus.bcfg3_we_i = 1'b0; bus.bcfg3_data_i = '0;

    #5;
    expect_now("reset", 16'h0001, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    write_regs(1, 1, 0, 16'h0002, 16'h0005, 16'h0000);
    expect_now("basic", 16'h0002, 16'h0005, 16'h0000);
    repeat (2) @(negedge clk);
    expect_now("hold", 16'h0002, 16'h0005, 16'h0000);

    write_regs(1, 1, 0, 16'h3C02, 16'hC005, 16'h0000);
    expect_now("split_shift", 16'h3C02, 16'hC005, 16'h0000);

    write_regs(1, 0, 1, 16'hFFFF, 16'h0000, 16'hFFFF);
`ifdef BCFG_ENGINE_CLAMP_EN
    expect_now("reserved", 16'h3C02, 16'hC005, 16'h003F);
`else
    expect_now("reserved", 16'h3FFF, 16'hC005, 16'h003F);
`endif

    write_regs(0, 0, 1, 16'hAAAA, 16'h5555, 16'h0015);
`ifdef BCFG_ENGINE_CLAMP_EN
    expect_now("bcfg3_only", 16'h3C02, 16'hC005, 16'h0015);
`else
    expect_now("bcfg3_only", 16'h3FFF, 16'hC005, 16'h0015);
`endif

    write_regs(0, 1, 0, 16'h0000, 16'hC005, 16'h0000);
`ifdef BCFG_ENGINE_CLAMP_EN
    expect_now("same_value", 16'h3C02, 16'hC005, 16'h0015);
`else
    expect_now("same_value", 16'h3FFF, 16'hC005, 16'h0015);
`endif

    // Reset asserted mid-cycle while a BCFG2 write is pending.
    @(negedge clk);
    bus.bcfg2_we_i = 1'b1;
    bus.bcfg2_data_i = 16'h1234;
    #2 rst = 1'b1;
    #1;
    expect_now("rst_async", 16'h0001, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    expect_now("rst_edge", 16'h0001, 16'h0000, 16'h0000);
    @(negedge clk);
    bus.bcfg2_we_i = 1'b0;
    rst = 1'b0;

    write_regs(1, 1, 1, 16'h1234, 16'hABCD, 16'hFFC5);
`ifdef BCFG_ENGINE_CLAMP_EN
    expect_now("all_three", 16'h1002, 16'hABCD, 16'h0005);
`else
    expect_now("all_three", 16'h1234, 16'hABCD, 16'h0005);
`endif

    write_regs(1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
`ifdef BCFG_ENGINE_CLAMP_EN
    expect_now("engine_zero", 16'h0001, 16'hABCD, 16'h0005);
`else
    expect_now("engine_zero", 16'h0000, 16'hABCD, 16'h0005);
`endif

    write_regs(1, 0, 0, 16'h0005, 16'h0000, 16'h0000);
`ifdef BCFG_ENGINE_CLAMP_EN
    expect_now("engine_five", 16'h0002, 16'hABCD, 16'h0005);
`else
    expect_now("engine_five", 16'h0005, 16'hABCD, 16'h0005);
`endif

    #2;
    check("scoreboard_drained", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
